// File: rtl/echo_emulator.sv
// HC-SR04 sensor-side stand-in: qualifies a trig pulse, then returns an echo
// whose width is the programmed distance in us. Optional macro ECHO_JITTER_EN.
module echo_emulator #(
  parameter int unsigned CLK_PER_US  = 40,
  parameter int unsigned MIN_TRIG_US = 10,
  parameter int unsigned LATENCY_US  = 250,
  parameter int unsigned MAX_ECHO_US = 38000,
  parameter int unsigned COOLDOWN_US = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig,
  input  logic [15:0] dist_us,
  output logic        echo,
  output logic        busy,
  output logic [7:0]  echo_count,
  output logic        short_trig
);
  localparam int unsigned MIN_CYC  = MIN_TRIG_US * CLK_PER_US;
  localparam int unsigned LAT_CYC  = LATENCY_US * CLK_PER_US;
  localparam int unsigned MAXE_CYC = MAX_ECHO_US * CLK_PER_US;
  localparam int unsigned COOL_CYC = COOLDOWN_US * CLK_PER_US;
  localparam int unsigned BIG_A    = (LAT_CYC > COOL_CYC) ? LAT_CYC : COOL_CYC;
  localparam int unsigned BIG      = (MAXE_CYC > BIG_A) ? MAXE_CYC : BIG_A;
  localparam int unsigned CYC_W    = ($clog2(BIG + 1) > 21) ? $clog2(BIG + 1) : 21;
  localparam int unsigned CNT_W    = $clog2(MIN_CYC + 1);

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_CYC);
  localparam logic [CYC_W-1:0] LAT_T  = CYC_W'(LAT_CYC - 1);
  localparam logic [CYC_W-1:0] COOL_T = CYC_W'(COOL_CYC - 1);
  localparam logic [15:0]      MAX_W  = 16'(MAX_ECHO_US);

  typedef enum logic [2:0] {S_IDLE, S_TRIG_HI, S_DELAY, S_ECHO, S_COOL} state_t;

  state_t           state_q;
  logic             trig_m_q, trig_s_q, trig_p_q;
  logic [2:0]       arm_q;
  logic [CNT_W-1:0] wcnt_q;
  logic [CYC_W-1:0] cyc_q;
  logic [15:0]      width_q;
  logic             echo_q, busy_q, short_q;
  logic [7:0]       count_q;

  logic             rise, fall, accept;
  logic [15:0]      w_base, w_sel;
  logic [CYC_W-1:0] echo_cyc;

  // Edges are only trusted once the synchronizer holds real samples, so a trig
  // already high at reset release is not mistaken for a rising edge.
  assign rise     = arm_q[2] & trig_s_q & ~trig_p_q;
  assign fall     = arm_q[2] & ~trig_s_q & trig_p_q;
  assign accept   = (state_q == S_TRIG_HI) && fall && (wcnt_q >= MIN_C);
  assign w_base   = (dist_us != '0 && dist_us <= MAX_W) ? dist_us : MAX_W;
  assign echo_cyc = CYC_W'(width_q) * CYC_W'(CLK_PER_US);

`ifdef ECHO_JITTER_EN
  logic [15:0]        lfsr_q, lfsr_d;
  logic signed [17:0] w_jit;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
  assign w_jit  = $signed({2'b00, w_base}) + $signed({{14{lfsr_d[3]}}, lfsr_d[3:0]});

  always_comb begin
    if (w_jit < 18'sd1)                          w_sel = 16'd1;
    else if (w_jit > $signed({2'b00, MAX_W}))    w_sel = MAX_W;
    else                                         w_sel = w_jit[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      lfsr_q <= 16'hACE1;
    else if (accept) lfsr_q <= lfsr_d;
  end
`else
  always_comb w_sel = w_base;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      trig_m_q <= 1'b0;
      trig_s_q <= 1'b0;
      trig_p_q <= 1'b0;
      arm_q    <= '0;
      wcnt_q   <= '0;
      cyc_q    <= '0;
      width_q  <= '0;
      echo_q   <= 1'b0;
      busy_q   <= 1'b0;
      short_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      trig_m_q <= trig;
      trig_s_q <= trig_m_q;
      trig_p_q <= trig_s_q;
      arm_q    <= {arm_q[1:0], 1'b1};
      unique case (state_q)
        S_IDLE: begin
          if (rise) begin
            wcnt_q  <= CNT_W'(1);
            state_q <= S_TRIG_HI;
          end
        end
        S_TRIG_HI: begin
          if (accept) begin
            width_q <= w_sel;
            busy_q  <= 1'b1;
            cyc_q   <= '0;
            state_q <= S_DELAY;
          end else if (fall) begin
            short_q <= 1'b1;
            state_q <= S_IDLE;
          end else if (wcnt_q != '1) begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        S_DELAY: begin
          if (cyc_q == LAT_T) begin
            cyc_q   <= '0;
            echo_q  <= 1'b1;
            state_q <= S_ECHO;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_ECHO: begin
          if (cyc_q == echo_cyc - 1'b1) begin
            cyc_q   <= '0;
            echo_q  <= 1'b0;
            count_q <= count_q + 1'b1;
            state_q <= S_COOL;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        S_COOL: begin
          if (cyc_q == COOL_T) begin
            cyc_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign echo       = echo_q;
  assign busy       = busy_q;
  assign echo_count = count_q;
  assign short_trig = short_q;

endmodule

// File: tb/tb_echo_emulator.sv
// Scoreboard bench for echo_emulator with scaled-down timing parameters.
module tb_echo_emulator;
  localparam int unsigned CPU      = 4;
  localparam int unsigned MINT     = 10;
  localparam int unsigned LAT      = 10;
  localparam int unsigned MAXE     = 380;
  localparam int unsigned COOL     = 5;
  localparam int unsigned LAT_CYC  = LAT * CPU;
  localparam int unsigned COOL_CYC = COOL * CPU;
  localparam int unsigned MIN_CYC  = MINT * CPU;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] dist_us = '0;
  logic        echo, busy, short_trig;
  logic [7:0]  echo_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned exp_q[$];
  int unsigned exp_cnt = 0;
  int unsigned n_echo = 0;
  bit          busy_seen = 1'b0;
  bit          echo_seen = 1'b0;

  echo_emulator #(
    .CLK_PER_US (CPU),
    .MIN_TRIG_US(MINT),
    .LATENCY_US (LAT),
    .MAX_ECHO_US(MAXE),
    .COOLDOWN_US(COOL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .trig      (trig),
    .dist_us   (dist_us),
    .echo      (echo),
    .busy      (busy),
    .echo_count(echo_count),
    .short_trig(short_trig)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int unsigned exp_width(input int unsigned d);
    int unsigned w;
    w = (d >= 1 && d <= MAXE) ? d : MAXE;
    return w * CPU;
  endfunction

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int unsigned hi, input logic [15:0] d, input bit accepted);
    dist_us = d;
    trig = 1'b1;
    cyc(hi);
    trig = 1'b0;
    if (accepted) begin
      exp_q.push_back(exp_width(int'(d)));
      exp_cnt++;
    end
  endtask

  task automatic wait_idle();
    int unsigned n;
    n = 0;
    cyc(4);
    while (busy === 1'b1 && n < 5000) begin
      cyc(1);
      n++;
    end
    check("idle_reached", busy, 0);
    cyc(3);
  endtask

  task automatic wait_echo(input logic lvl, input string tag);
    int unsigned n;
    n = 0;
    while (echo !== lvl && n < 5000) begin
      cyc(1);
      n++;
    end
    check(tag, echo, lvl);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2);
    check("rst_echo", echo, 0);
    check("rst_busy", busy, 0);
    check("rst_count", echo_count, 0);
    check("rst_short", short_trig, 0);
    exp_q.delete();
    exp_cnt = 0;
    reset = 1'b1;
    cyc(3);
  endtask

  // Echo monitor: measures each pulse at negedge and pops the scoreboard.
  initial begin
    int unsigned run;
    int unsigned w;
    int unsigned lo, hi;
    bit prev;
    run = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        run = 0;
        prev = 1'b0;
      end else begin
        if (busy === 1'b1) busy_seen = 1'b1;
        if (echo === 1'b1) begin
          echo_seen = 1'b1;
          run++;
        end
        if (echo !== 1'b1 && prev) begin
          n_echo++;
          if (exp_q.size() == 0) begin
            check("unexpected_echo", 1, 0);
          end else begin
            w = exp_q.pop_front();
`ifdef ECHO_JITTER_EN
            lo = (w / CPU > 8) ? w / CPU - 8 : 1;
            hi = (w / CPU + 7 < MAXE) ? w / CPU + 7 : MAXE;
            check("echo_width_jit", (run % CPU == 0) && (run >= lo * CPU) && (run <= hi * CPU), 1);
`else
            check("echo_width", run, w);
`endif
          end
          run = 0;
        end
        prev = echo;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    int unsigned e0;

    cyc(3);
    do_reset();

    // Nominal pulse with latency, width and cooldown measured directly.
    dist_us = 16'd100;
    trig = 1'b1;
    cyc(80);
    trig = 1'b0;
    exp_q.push_back(exp_width(100));
    exp_cnt++;
    n = 0;
    while (echo !== 1'b1 && n < 1000) begin cyc(1); n++; end
    check("latency", (n >= LAT_CYC + 2) && (n <= LAT_CYC + 4), 1);
    check("busy_in_echo", busy, 1);
    n = 0;
    while (echo === 1'b1 && n < 5000) begin cyc(1); n++; end
`ifndef ECHO_JITTER_EN
    check("width_direct", n, 100 * CPU);
`endif
    check("count_1", echo_count, 1);
    n = 0;
    while (busy === 1'b1 && n < 5000) begin cyc(1); n++; end
    check("cooldown", n, COOL_CYC);
    cyc(3);

    // Triggers during ECHO and COOL are ignored.
    pulse(80, 16'd100, 1'b1);
    wait_echo(1'b1, "echo_rise_t4");
    cyc(50);
    pulse(80, 16'd7, 1'b0);
    cyc(20);
    pulse(5, 16'd7, 1'b0);
    wait_echo(1'b0, "echo_fall_t4");
    cyc(2);
    pulse(80, 16'd7, 1'b0);
    wait_idle();
    cyc(80);
    check("count_ignored", echo_count, 8'(exp_cnt));
    check("short_not_set", short_trig, 0);
    check("queue_empty_t4", exp_q.size(), 0);

    // Short trigger in IDLE, sticky flag survives a valid trigger.
    busy_seen = 1'b0;
    echo_seen = 1'b0;
    pulse(20, 16'd100, 1'b0);
    cyc(100);
    check("short_set", short_trig, 1);
    check("short_no_busy", busy_seen, 0);
    check("short_no_echo", echo_seen, 0);
    pulse(MIN_CYC, 16'd20, 1'b1);
    wait_idle();
    check("short_sticky", short_trig, 1);
    check("count_min_trig", echo_count, 8'(exp_cnt));

    do_reset();
    busy_seen = 1'b0;
    pulse(MIN_CYC - 1, 16'd20, 1'b0);
    cyc(80);
    check("short_boundary", short_trig, 1);
    check("boundary_no_busy", busy_seen, 0);

    // Range clamping and sampling of dist_us only at acceptance.
    pulse(44, 16'd0, 1'b1);
    wait_idle();
    pulse(44, 16'd50000, 1'b1);
    wait_idle();
    pulse(44, 16'(MAXE), 1'b1);
    wait_idle();
    pulse(44, 16'(MAXE + 1), 1'b1);
    wait_idle();
    pulse(44, 16'd200, 1'b1);
    cyc(10);
    dist_us = 16'd5;
    wait_idle();
    check("count_t3", echo_count, 8'(exp_cnt));
    check("queue_empty_t3", exp_q.size(), 0);

    // Reset in the middle of an echo, with trig held high across release.
    pulse(44, 16'(MAXE), 1'b1);
    wait_echo(1'b1, "echo_rise_t5");
    cyc(100);
    reset = 1'b0;
    trig = 1'b1;
    #1;
    check("midrst_echo", echo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", echo_count, 0);
    exp_q.delete();
    exp_cnt = 0;
    cyc(5);
    echo_seen = 1'b0;
    busy_seen = 1'b0;
    reset = 1'b1;
    cyc(44);
    trig = 1'b0;
    cyc(150);
    check("post_rst_no_echo", echo_seen, 0);
    check("post_rst_no_busy", busy_seen, 0);
    pulse(44, 16'd1, 1'b1);
    wait_idle();
    check("post_rst_count", echo_count, 1);

    // 256 back-to-back triggers wrap the completed-echo counter.
    do_reset();
    e0 = n_echo;
    for (int i = 0; i < 256; i++) begin
      pulse(44, 16'd1, 1'b1);
      wait_idle();
    end
    check("wrap_count", echo_count, 0);
    check("wrap_echoes", n_echo - e0, 256);
    check("queue_empty_end", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
